// File: rtl/pipe_pkg.sv
// Shared constants and encodings for the pipeline hazard/forwarding controller.
package pipe_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int RIDX_W_DEF    = 4;
    localparam int OPC_W_DEF     = 4;
    localparam int DRAIN_CYC_DEF = 4;
    localparam int CNT_W_DEF     = 16;

    localparam logic [3:0] HALT_OPC = 4'b1110;

    // Operand source selected for the ID/EX register
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_e;

    // Halt sequencing states
    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } hz_state_e;

endpackage

// File: rtl/fwd_mux.sv
// Single-operand priority forwarding unit: youngest producer wins, index 0 never forwards.
module fwd_mux
    import pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int RIDX_W = 4
) (
    input  logic [RIDX_W-1:0] src_i,
    input  logic [RIDX_W-1:0] ex_dest_i,
    input  logic [RIDX_W-1:0] mem_dest_i,
    input  logic [RIDX_W-1:0] wb_dest_i,
    input  logic              ex_wen_i,
    input  logic              mem_wen_i,
    input  logic              wb_wen_i,
    input  logic              ex_is_load_i,
    input  logic [DATA_W-1:0] ex_data_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic [1:0]        sel_o,
    output logic [DATA_W-1:0] data_o
);

    fwd_sel_e sel;

    // Pick the youngest matching producer; a load in EX has no data yet, so it is skipped
    always_comb begin
        sel = FWD_RF;
        if (src_i != '0) begin
            if (ex_wen_i && (ex_dest_i == src_i) && !ex_is_load_i) begin
                sel = FWD_EX;
            end else if (mem_wen_i && (mem_dest_i == src_i)) begin
                sel = FWD_MEM;
            end else if (wb_wen_i && (wb_dest_i == src_i)) begin
                sel = FWD_WB;
            end
        end
    end

    // Operand mux follows the select
    always_comb begin
        data_o = rf_data_i;
        case (sel)
            FWD_EX:  data_o = ex_data_i;
            FWD_MEM: data_o = mem_data_i;
            FWD_WB:  data_o = wb_data_i;
            default: data_o = rf_data_i;
        endcase
    end

    assign sel_o = sel;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and halt-drain controller for the IF/ID/EX/MEM/WB pipeline.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RUN    | normal issue; forwarding and load-use stalls active
// ST_DRAIN  | halt held in IF while older instructions retire
// ST_HALTED | pipeline empty; everything frozen until reset
module pipe_hazard_ctrl #(
    parameter int                    DATA_W    = pipe_pkg::DATA_W_DEF,
    parameter int                    RIDX_W    = pipe_pkg::RIDX_W_DEF,
    parameter int                    OPC_W     = pipe_pkg::OPC_W_DEF,
    parameter logic [OPC_W-1:0]      HALT_OPC  = pipe_pkg::HALT_OPC,
    parameter int                    DRAIN_CYC = pipe_pkg::DRAIN_CYC_DEF,
    parameter int                    CNT_W     = pipe_pkg::CNT_W_DEF
) (
    input  logic              clkwire,
    input  logic              rst,
    input  logic [OPC_W-1:0]  if_opcode,
    input  logic [RIDX_W-1:0] id_src1,
    input  logic [RIDX_W-1:0] id_src2,
    input  logic [RIDX_W-1:0] ex_dest,
    input  logic [RIDX_W-1:0] mem_dest,
    input  logic [RIDX_W-1:0] wb_dest,
    input  logic              ex_wen,
    input  logic              mem_wen,
    input  logic              wb_wen,
    input  logic              ex_is_load,
    input  logic [DATA_W-1:0] ex_alu,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic              ex_jump_taken,
    output logic [DATA_W-1:0] op1_out,
    output logic [DATA_W-1:0] op2_out,
    output logic [1:0]        fwd_sel1,
    output logic [1:0]        fwd_sel2,
    output logic              stall_if,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic              flush_if,
    output logic              flush_id,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    import pipe_pkg::*;

    // Drain counter only needs to hold DRAIN_CYC-1
    localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYC - 1);

    hz_state_e        state_q, state_d;
    logic [DCW-1:0]   drain_q, drain_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;
    logic             count_stall;

    fwd_mux #(.DATA_W(DATA_W), .RIDX_W(RIDX_W)) u_fwd1 (
        .src_i        (id_src1),
        .ex_dest_i    (ex_dest),
        .mem_dest_i   (mem_dest),
        .wb_dest_i    (wb_dest),
        .ex_wen_i     (ex_wen),
        .mem_wen_i    (mem_wen),
        .wb_wen_i     (wb_wen),
        .ex_is_load_i (ex_is_load),
        .ex_data_i    (ex_alu),
        .mem_data_i   (mem_wdata),
        .wb_data_i    (wb_wdata),
        .rf_data_i    (rf_data1),
        .sel_o        (fwd_sel1),
        .data_o       (op1_out)
    );

    fwd_mux #(.DATA_W(DATA_W), .RIDX_W(RIDX_W)) u_fwd2 (
        .src_i        (id_src2),
        .ex_dest_i    (ex_dest),
        .mem_dest_i   (mem_dest),
        .wb_dest_i    (wb_dest),
        .ex_wen_i     (ex_wen),
        .mem_wen_i    (mem_wen),
        .wb_wen_i     (wb_wen),
        .ex_is_load_i (ex_is_load),
        .ex_data_i    (ex_alu),
        .mem_data_i   (mem_wdata),
        .wb_data_i    (wb_wdata),
        .rf_data_i    (rf_data2),
        .sel_o        (fwd_sel2),
        .data_o       (op2_out)
    );

    // A load in EX whose destination feeds the instruction in ID
    assign load_use = ex_is_load && ex_wen && (ex_dest != '0) &&
                      ((ex_dest == id_src1) || (ex_dest == id_src2));

    // Next state, drain countdown and pipeline control; a taken jump overrides any stall
    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        bubble_ex   = 1'b0;
        halted      = 1'b0;
        flush_if    = ex_jump_taken;
        flush_id    = ex_jump_taken;
        count_stall = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!ex_jump_taken) begin
                    stall_if    = load_use;
                    stall_id    = load_use;
                    bubble_ex   = load_use;
                    count_stall = load_use;
                    if (if_opcode == HALT_OPC) begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end
                end
            end
            ST_DRAIN: begin
                if (ex_jump_taken) begin
                    // halt was on a mispredicted path
                    state_d = ST_RUN;
                    drain_d = '0;
                end else begin
                    stall_if    = 1'b1;
                    stall_id    = load_use;
                    bubble_ex   = load_use;
                    count_stall = load_use;
                    if (drain_q == '0) begin
                        state_d = ST_HALTED;
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                halted    = 1'b1;
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
                drain_d = '0;
            end
        endcase
    end

    // Saturating debug counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (count_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (ex_jump_taken && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge clkwire) begin
        if (rst) begin
            state_q     <= ST_RUN;
            drain_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver queues hand-computed expectations,
// monitor compares them on the falling edge.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  if_opcode;
    logic [3:0]  id_src1, id_src2, ex_dest, mem_dest, wb_dest;
    logic        ex_wen, mem_wen, wb_wen, ex_is_load, ex_jump_taken;
    logic [15:0] ex_alu, mem_wdata, wb_wdata, rf_data1, rf_data2;

    logic [15:0] op1_out, op2_out;
    logic [1:0]  fwd_sel1, fwd_sel2;
    logic        stall_if, stall_id, bubble_ex, flush_if, flush_id, halted;
    logic [15:0] stall_cnt, flush_cnt;

    logic [15:0] op1_4, op2_4;
    logic [1:0]  sel1_4, sel2_4;
    logic        sif_4, sid_4, bub_4, fif_4, fid_4, hal_4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    typedef struct packed {
        logic [1:0]  sel1;
        logic [1:0]  sel2;
        logic [15:0] op1;
        logic [15:0] op2;
        logic        sif;
        logic        sid;
        logic        bub;
        logic        fif;
        logic        fid;
        logic        hal;
        logic [15:0] sc;
        logic [15:0] fc;
        logic [3:0]  sc4;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    pipe_hazard_ctrl u_dut (
        .clkwire(clk), .rst(rst), .if_opcode(if_opcode),
        .id_src1(id_src1), .id_src2(id_src2),
        .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
        .ex_wen(ex_wen), .mem_wen(mem_wen), .wb_wen(wb_wen),
        .ex_is_load(ex_is_load),
        .ex_alu(ex_alu), .mem_wdata(mem_wdata), .wb_wdata(wb_wdata),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .ex_jump_taken(ex_jump_taken),
        .op1_out(op1_out), .op2_out(op2_out),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
        .flush_if(flush_if), .flush_id(flush_id), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) u_dut4 (
        .clkwire(clk), .rst(rst), .if_opcode(if_opcode),
        .id_src1(id_src1), .id_src2(id_src2),
        .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
        .ex_wen(ex_wen), .mem_wen(mem_wen), .wb_wen(wb_wen),
        .ex_is_load(ex_is_load),
        .ex_alu(ex_alu), .mem_wdata(mem_wdata), .wb_wdata(wb_wdata),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .ex_jump_taken(ex_jump_taken),
        .op1_out(op1_4), .op2_out(op2_4),
        .fwd_sel1(sel1_4), .fwd_sel2(sel2_4),
        .stall_if(sif_4), .stall_id(sid_4), .bubble_ex(bub_4),
        .flush_if(fif_4), .flush_id(fid_4), .halted(hal_4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [1:0] s1, input logic [1:0] s2,
                                input logic [15:0] o1, input logic [15:0] o2,
                                input logic sif, input logic sid, input logic bub,
                                input logic fif, input logic fid, input logic hal,
                                input logic [15:0] sc, input logic [15:0] fc,
                                input logic [3:0] sc4);
        exp_t e;
        e.sel1 = s1;  e.sel2 = s2;  e.op1 = o1;  e.op2 = o2;
        e.sif = sif;  e.sid = sid;  e.bub = bub;
        e.fif = fif;  e.fid = fid;  e.hal = hal;
        e.sc = sc;    e.fc = fc;    e.sc4 = sc4;
        return e;
    endfunction

    task automatic defaults();
        if_opcode = 4'h0;
        id_src1 = 4'd0; id_src2 = 4'd0;
        ex_dest = 4'd0; mem_dest = 4'd0; wb_dest = 4'd0;
        ex_wen = 1'b0; mem_wen = 1'b0; wb_wen = 1'b0;
        ex_is_load = 1'b0; ex_jump_taken = 1'b0;
        ex_alu = 16'hAAAA; mem_wdata = 16'hBBBB; wb_wdata = 16'hCCCC;
        rf_data1 = 16'h1111; rf_data2 = 16'h2222;
    endtask

    task automatic load_use5();
        ex_is_load = 1'b1; ex_wen = 1'b1; ex_dest = 4'd5;
    endtask

    // Queue the expectation for the inputs just applied, then advance one cycle
    task automatic issue(input string nm, input exp_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        defaults();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Monitor: compare combinational outputs and counters mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = mk(fwd_sel1, fwd_sel2, op1_out, op2_out, stall_if, stall_id,
                    bubble_ex, flush_if, flush_id, halted, stall_cnt, flush_cnt,
                    stall_cnt4);
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got sel=%b/%b op=%h/%h sif=%b sid=%b bub=%b fif=%b fid=%b hal=%b sc=%0d fc=%0d sc4=%0d, want sel=%b/%b op=%h/%h sif=%b sid=%b bub=%b fif=%b fid=%b hal=%b sc=%0d fc=%0d sc4=%0d",
                         nm, a.sel1, a.sel2, a.op1, a.op2, a.sif, a.sid, a.bub,
                         a.fif, a.fid, a.hal, a.sc, a.fc, a.sc4,
                         e.sel1, e.sel2, e.op1, e.op2, e.sif, e.sid, e.bub,
                         e.fif, e.fid, e.hal, e.sc, e.fc, e.sc4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d tests run", n_tests);
        $fatal(1, "timeout");
    end

    initial begin
        defaults();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        defaults();
        issue("reset_state", mk(2'b00, 2'b00, 16'h1111, 16'h2222, 0,0,0, 0,0,0, 16'd0, 16'd0, 4'd0));

        defaults(); ex_dest = 4'd3; ex_wen = 1'b1; ex_alu = 16'h0042; id_src1 = 4'd3;
        issue("fwd_ex", mk(2'b01, 2'b00, 16'h0042, 16'h2222, 0,0,0, 0,0,0, 16'd0, 16'd0, 4'd0));

        defaults(); mem_dest = 4'd3; mem_wen = 1'b1; id_src1 = 4'd3;
        issue("fwd_mem", mk(2'b10, 2'b00, 16'hBBBB, 16'h2222, 0,0,0, 0,0,0, 16'd0, 16'd0, 4'd0));

        defaults(); wb_dest = 4'd3; wb_wen = 1'b1; id_src1 = 4'd3;
        issue("fwd_wb", mk(2'b11, 2'b00, 16'hCCCC, 16'h2222, 0,0,0, 0,0,0, 16'd0, 16'd0, 4'd0));

        defaults(); ex_dest = 4'd3; mem_dest = 4'd3; wb_dest = 4'd3;
        ex_wen = 1'b1; mem_wen = 1'b1; wb_wen = 1'b1; id_src1 = 4'd3; id_src2 = 4'd3;
        issue("fwd_ex_priority", mk(2'b01, 2'b01, 16'hAAAA, 16'hAAAA, 0,0,0, 0,0,0, 16'd0, 16'd0, 4'd0));

        defaults(); ex_dest = 4'd0; ex_wen = 1'b1; id_src2 = 4'd0;
        issue("src_zero", mk(2'b00, 2'b00, 16'h1111, 16'h2222, 0,0,0, 0,0,0, 16'd0, 16'd0, 4'd0));

        defaults(); load_use5(); id_src2 = 4'd5;
        issue("load_use", mk(2'b00, 2'b00, 16'h1111, 16'h2222, 1,1,1, 0,0,0, 16'd0, 16'd0, 4'd0));

        defaults(); mem_dest = 4'd5; mem_wen = 1'b1; id_src2 = 4'd5;
        issue("load_use_resolve", mk(2'b00, 2'b10, 16'h1111, 16'hBBBB, 0,0,0, 0,0,0, 16'd1, 16'd0, 4'd1));

        defaults(); load_use5(); id_src2 = 4'd5; ex_jump_taken = 1'b1;
        issue("jump_over_stall", mk(2'b00, 2'b00, 16'h1111, 16'h2222, 0,0,0, 1,1,0, 16'd1, 16'd0, 4'd1));

        defaults();
        issue("counts_after_jump", mk(2'b00, 2'b00, 16'h1111, 16'h2222, 0,0,0, 0,0,0, 16'd1, 16'd1, 4'd1));

        defaults(); if_opcode = 4'b1110;
        issue("halt_detect", mk(2'b00, 2'b00, 16'h1111, 16'h2222, 0,0,0, 0,0,0, 16'd1, 16'd1, 4'd1));
        defaults(); if_opcode = 4'b1110;
        issue("drain_c3", mk(2'b00, 2'b00, 16'h1111, 16'h2222, 1,0,0, 0,0,0, 16'd1, 16'd1, 4'd1));
        defaults(); if_opcode = 4'b1110; load_use5(); id_src1 = 4'd5;
        issue("drain_c2_loaduse", mk(2'b00, 2'b00, 16'h1111, 16'h2222, 1,1,1, 0,0,0, 16'd1, 16'd1, 4'd1));
        defaults(); if_opcode = 4'b1110;
        issue("drain_c1", mk(2'b00, 2'b00, 16'h1111, 16'h2222, 1,0,0, 0,0,0, 16'd2, 16'd1, 4'd2));
        defaults(); if_opcode = 4'b1110;
        issue("drain_c0", mk(2'b00, 2'b00, 16'h1111, 16'h2222, 1,0,0, 0,0,0, 16'd2, 16'd1, 4'd2));
        defaults(); if_opcode = 4'b1110;
        issue("halted_rise", mk(2'b00, 2'b00, 16'h1111, 16'h2222, 1,1,1, 0,0,1, 16'd2, 16'd1, 4'd2));
        defaults(); if_opcode = 4'b1110; load_use5(); id_src1 = 4'd5;
        issue("halted_loaduse", mk(2'b00, 2'b00, 16'h1111, 16'h2222, 1,1,1, 0,0,1, 16'd2, 16'd1, 4'd2));
        defaults();
        issue("halted_hold", mk(2'b00, 2'b00, 16'h1111, 16'h2222, 1,1,1, 0,0,1, 16'd2, 16'd1, 4'd2));

        do_reset();
        issue("rst_from_halted", mk(2'b00, 2'b00, 16'h1111, 16'h2222, 0,0,0, 0,0,0, 16'd0, 16'd0, 4'd0));

        defaults(); if_opcode = 4'b1110;
        issue("halt2_detect", mk(2'b00, 2'b00, 16'h1111, 16'h2222, 0,0,0, 0,0,0, 16'd0, 16'd0, 4'd0));
        defaults(); if_opcode = 4'b1110;
        issue("halt2_drain_c3", mk(2'b00, 2'b00, 16'h1111, 16'h2222, 1,0,0, 0,0,0, 16'd0, 16'd0, 4'd0));
        defaults(); if_opcode = 4'b1110; ex_jump_taken = 1'b1;
        issue("halt2_jump", mk(2'b00, 2'b00, 16'h1111, 16'h2222, 0,0,0, 1,1,0, 16'd0, 16'd0, 4'd0));
        defaults();
        issue("halt2_back_run", mk(2'b00, 2'b00, 16'h1111, 16'h2222, 0,0,0, 0,0,0, 16'd0, 16'd1, 4'd0));

        defaults(); if_opcode = 4'b1110; ex_jump_taken = 1'b1;
        issue("halt_squashed", mk(2'b00, 2'b00, 16'h1111, 16'h2222, 0,0,0, 1,1,0, 16'd0, 16'd1, 4'd0));
        defaults();
        issue("halt_squashed_run", mk(2'b00, 2'b00, 16'h1111, 16'h2222, 0,0,0, 0,0,0, 16'd0, 16'd2, 4'd0));

        defaults(); if_opcode = 4'b1110;
        issue("halt3_detect", mk(2'b00, 2'b00, 16'h1111, 16'h2222, 0,0,0, 0,0,0, 16'd0, 16'd2, 4'd0));
        defaults(); if_opcode = 4'b1110;
        issue("halt3_drain", mk(2'b00, 2'b00, 16'h1111, 16'h2222, 1,0,0, 0,0,0, 16'd0, 16'd2, 4'd0));
        do_reset();
        issue("rst_mid_drain", mk(2'b00, 2'b00, 16'h1111, 16'h2222, 0,0,0, 0,0,0, 16'd0, 16'd0, 4'd0));

        for (int i = 0; i < 20; i++) begin
            defaults(); load_use5(); id_src2 = 4'd5;
            @(posedge clk); #1;
        end
        defaults();
        issue("stall_saturate", mk(2'b00, 2'b00, 16'h1111, 16'h2222, 0,0,0, 0,0,0, 16'd20, 16'd0, 4'd15));

        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard, forwarding and halt-drain controller for the 5-stage IF/ID/EX/MEM/WB pipeline. It replaces the fixed top-level drain countdown with a proper controller.
- Decides operand forwarding into EX and detects load-use stalls.
- Squashes younger stages on a taken jump.
- Runs an explicit RUN/DRAIN/HALTED machine when the halt opcode reaches IF.
- Keeps saturating stall and flush counters for debug.

Parameters:
DATA_W, 16, register/ALU data width
RIDX_W, 4, register index width; index 0 means "no register" and is never forwarded
OPC_W, 4, opcode width
HALT_OPC, 4'b1110, opcode that starts the halt drain
DRAIN_CYC, 4, cycles after halt detection before HALTED (number of stages behind IF)
CNT_W, 16, width of the performance counters

Ports:
clkwire  in  1  pipeline clock; all state updates on posedge
rst  in  1  synchronous active-high reset
if_opcode  in  OPC_W  opcode of the instruction currently in IF
id_src1, id_src2  in  RIDX_W  source register indices of the instruction in ID
ex_dest, mem_dest, wb_dest  in  RIDX_W  destination index per stage
ex_wen, mem_wen, wb_wen  in  1  stage will write a register
ex_is_load  in  1  instruction in EX is a load
ex_alu, mem_wdata, wb_wdata  in  DATA_W  candidate forward data
rf_data1, rf_data2  in  DATA_W  register-file read data for ID sources
ex_jump_taken  in  1  EX resolved a taken jump
op1_out, op2_out  out  DATA_W  forwarded operands for the ID/EX register
fwd_sel1, fwd_sel2  out  2  00 regfile, 01 EX, 10 MEM, 11 WB
stall_if, stall_id  out  1  hold PC and IF/ID register
bubble_ex  out  1  load NOP into ID/EX
flush_if, flush_id  out  1  squash IF/ID and ID/EX contents
halted  out  1  pipeline fully drained
stall_cnt, flush_cnt  out  CNT_W  saturating event counters

Behaviour:
Reset values:
- All state is cleared: FSM=RUN, drain counter=0, stall_cnt=0, flush_cnt=0, halted=0.
- Outputs are combinationally derived from inputs plus this state; flush/stall/bubble are 0 unless their condition holds.

Forwarding (combinational, zero latency), per source:
- Source index 0 always takes fwd_sel=00 and the regfile value.
- Otherwise use the first match in priority order: EX (ex_wen and ex_dest==src and not ex_is_load), then MEM, then WB, then regfile.
- The op*_out mux follows fwd_sel.

Load-use stall:
- Condition: ex_is_load and ex_wen and ex_dest!=0 and ex_dest matches id_src1 or id_src2.
- Asserts stall_if=stall_id=bubble_ex=1 for exactly that cycle.
- On the next cycle the load is in MEM, and forwarding from MEM resolves the dependency.

Jump:
- ex_jump_taken asserts flush_if=flush_id=1 in the same cycle.
- Jump has priority over load-use: on a simultaneous event, stall outputs are 0.

FSM:
- RUN: if_opcode==HALT_OPC and not flush_if → DRAIN, counter loaded with DRAIN_CYC-1. A halt opcode being squashed by a jump does not start the drain.
- DRAIN:
  - stall_if=1 holds the halt in IF.
  - The counter decrements every cycle. Load-use stalls do not pause it; the older instructions still retire.
  - Counter==0 → HALTED.
  - A taken jump in DRAIN returns to RUN and clears the counter. The halt was speculative.
- HALTED: halted=1, stall_if=stall_id=bubble_ex=1. Only rst leaves this state.
- rst mid-DRAIN returns to RUN at the next edge.

Counters:
- stall_cnt increments on each cycle with a load-use stall in RUN or DRAIN. HALTED stalls are not counted.
- flush_cnt increments on each ex_jump_taken.
- Both saturate at all-ones; no wrap-around.

Decomposition:
- Shared package pipe_pkg: opcode constants (HALT_OPC), the fwd_sel encodings (FWD_RF/EX/MEM/WB), FSM state encodings (ST_RUN, ST_DRAIN, ST_HALTED) and the default widths.
- One sub-module, fwd_mux: a single-operand priority forwarding unit, instantiated twice.

Test Plan:
- Reset, then ex_dest=3/ex_wen=1/ex_alu=16'h0042, id_src1=3 → fwd_sel1=01, op1_out=0042. Repeat with mem only (sel 10) and wb only (sel 11). With all three matching, EX wins.
- id_src2=0, ex_dest=0, ex_wen=1 → fwd_sel2=00, op2_out=rf_data2.
- ex_is_load=1, ex_dest=5, id_src2=5 → stall_if/stall_id/bubble_ex=1 for one cycle and stall_cnt 0→1. Next cycle: mem_dest=5 gives fwd_sel2=10 and no stall.
- Load-use and ex_jump_taken in the same cycle → flush_if=flush_id=1, stalls 0, flush_cnt=1, stall_cnt unchanged.
- if_opcode=1110 in RUN → DRAIN; halted rises exactly 4 cycles later and stays high. A second run with ex_jump_taken at drain cycle 2 returns to RUN with halted=0. rst in HALTED clears everything.
- CNT_W=4 build: 20 load-use stalls → stall_cnt saturates at 15.
